cache_lsu_port: RTL and testbench
=================================

Name: cache_lsu_port

Overview:
- Initiator for the cache controller's p0 request/response port.
- Takes byte/half/word load/store requests from the core and issues word-aligned cache requests with byte write masks.
- Tracks up to MAX_OUTSTANDING in-order requests and returns aligned, sign/zero-extended load data to the core.
- Rejects misaligned accesses locally with an in-order error response; these never reach the cache.

Parameters:
- MAX_OUTSTANDING, 2, depth of the in-flight tag FIFO (power of two, >=1); counts requests from core accept until core response handshake.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low (asserted when 0)
- core_req_vld_i  in  1  core request valid
- core_req_rdy_o  out  1  core request ready
- core_req_addr_i  in  32  byte address
- core_req_we_i  in  1  1 = store, 0 = load
- core_req_size_i  in  2  0 byte, 1 half, 2 word, 3 reserved
- core_req_signed_i  in  1  sign-extend load result
- core_req_wdat_i  in  32  store data, LSB-aligned
- core_rsp_vld_o  out  1  response valid
- core_rsp_rdy_i  in  1  response ready
- core_rsp_dat_o  out  32  load result (0 for stores and errors)
- core_rsp_err_o  out  1  misaligned/reserved-size error
- p0_uvld_o  out  1  cache request valid
- p0_urdy_i  in  1  cache request ready
- p0_addr_o  out  32  word address, bits [1:0] = 0
- p0_web_o  out  1  active-low write enable (0 = write)
- p0_wdat_o  out  32  lane-replicated store data
- p0_wmask_o  out  4  byte lane mask
- p0_dvld_i  in  1  cache response valid
- p0_drdy_o  out  1  cache response ready
- p0_ddat_i  in  32  cache response word

Behaviour:
- Reset (reset=0, async):
  - p0_uvld_o=0, p0_addr_o=0, p0_wdat_o=0, p0_wmask_o=0, p0_web_o=1.
  - FIFO emptied, so core_rsp_vld_o=0 and core_rsp_err_o=0.
  - core_req_rdy_o=1.
  - Reset mid-operation drops all in-flight state; the cache is reset together with this block.
- Tag FIFO: entry = {err, we, size, signed, off[1:0]}. Pointers wrap modulo MAX_OUTSTANDING; a separate count distinguishes full from empty.
- core_req_rdy_o = !full && (!p0_uvld_o || p0_urdy_i). Ready does not depend on a same-cycle pop; a full FIFO always stalls one cycle.
- Accept (vld && rdy): always push one FIFO entry.
- Misaligned accesses are: size=1 with off[0]=1, size=2 with off!=0, and size=3.
  - Misaligned: push err=1; no p0 request is issued.
  - Aligned: register p0 outputs; p0_uvld_o=1 from the next cycle (1-cycle issue latency).
- p0 request encoding:
  - Store: p0_web_o=0; wmask byte=1<<off, half=3<<off, word=4'hF; wdat byte={4{wdat[7:0]}}, half={2{wdat[15:0]}}, word=wdat.
  - Load: p0_web_o=1, wmask=0, wdat=0.
- p0 hold rule: while p0_uvld_o && !p0_urdy_i, all p0_* request outputs are held stable.
  - On handshake without a new accept, p0_uvld_o drops to 0 the next cycle.
  - Back-to-back handshakes are allowed (1 request per cycle).
- Response path is combinational from the FIFO head:
  - core_rsp_vld_o = !empty && (head.err || p0_dvld_i).
  - p0_drdy_o = !empty && !head.err && core_rsp_rdy_i.
  - Pop on core_rsp_vld_o && core_rsp_rdy_i.
  - An err head is returned without consuming p0 data; p0_dvld_i is held off meanwhile, preserving order.
- Load data extraction:
  - byte = p0_ddat_i[8*off+:8]; half = p0_ddat_i[16*off[1]+:16]; word unchanged.
  - Zero- or sign-extend per head.signed.
- core_rsp_dat_o = 0 for stores and errors; core_rsp_err_o = head.err when valid, else 0.
- Simultaneous push and pop: both take effect; count unchanged.
- p0_dvld_i with empty FIFO or err head: protocol violation; p0_drdy_o=0, data ignored, simulation assertion fires.

Optional Feature:
- Macro: CACHE_LSU_PORT_STATS_EN.
- Defined: adds input stat_clr_i and 16-bit outputs stat_load_cnt_o, stat_store_cnt_o and stat_stall_cnt_o.
  - Load/store counters increment on each p0 handshake of that type.
  - Stall counter increments each cycle p0_uvld_o && !p0_urdy_i.
  - All counters saturate at 16'hFFFF and clear on reset or stat_clr_i (clear wins over increment).
- Undefined: these ports and registers are absent; behaviour otherwise identical.

Test Plan:
- Store byte addr=0x1003 wdat=0xA5, urdy=1 -> next cycle p0_addr_o=0x1000, web=0, wmask=4'b1000, wdat=0xA5A5A5A5; response err=0, dat=0.
- Signed half load addr=0x2002, cache returns 0x8001_1234 -> core_rsp_dat_o=0xFFFF8001; unsigned -> 0x00008001.
- Word load addr=0x3001 -> no p0_uvld_o; core_rsp_vld_o=1, err=1, dat=0 the following cycle.
- Pipeline order: aligned load A, misaligned B, load C with MAX_OUTSTANDING=2 -> core_req_rdy_o=0 after A and B accepted; responses return A (data), then B (err), then C; B is not returned before A's data.
- Backpressure: p0_urdy_i=0 for 5 cycles -> p0_* request outputs stable all 5 cycles, then exactly one handshake; with STATS_EN, stat_stall_cnt_o=5.
- Assert reset mid-flight with 2 outstanding -> next cycle p0_uvld_o=0, core_rsp_vld_o=0, core_req_rdy_o=1.

Source files
------------

// File: rtl/cache_lsu_port.sv
// Core load/store initiator for the cache p0 port with an in-order tag FIFO.
// Define CACHE_LSU_PORT_STATS_EN to add saturating load/store/stall counters.
module cache_lsu_port #(
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        core_req_vld_i,
   output logic        core_req_rdy_o,
   input  logic [31:0] core_req_addr_i,
   input  logic        core_req_we_i,
   input  logic [1:0]  core_req_size_i,
   input  logic        core_req_signed_i,
   input  logic [31:0] core_req_wdat_i,
   output logic        core_rsp_vld_o,
   input  logic        core_rsp_rdy_i,
   output logic [31:0] core_rsp_dat_o,
   output logic        core_rsp_err_o,
   output logic        p0_uvld_o,
   input  logic        p0_urdy_i,
   output logic [31:0] p0_addr_o,
   output logic        p0_web_o,
   output logic [31:0] p0_wdat_o,
   output logic [3:0]  p0_wmask_o,
   input  logic        p0_dvld_i,
   output logic        p0_drdy_o,
   input  logic [31:0] p0_ddat_i
`ifdef CACHE_LSU_PORT_STATS_EN
   ,
   input  logic        stat_clr_i,
   output logic [15:0] stat_load_cnt_o,
   output logic [15:0] stat_store_cnt_o,
   output logic [15:0] stat_stall_cnt_o
`endif
);

   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(MAX_OUTSTANDING);

   typedef struct packed {
      logic       err;
      logic       we;
      logic [1:0] size;
      logic       sgn;
      logic [1:0] off;
   } tag_t;

   tag_t          fifo_r [MAX_OUTSTANDING];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] cnt_r;
   logic          full_s;
   logic          empty_s;
   logic          push_s;
   logic          pop_s;
   logic          mis_s;
   tag_t          new_tag_s;
   tag_t          head_s;
   logic [31:0]   ext_s;

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      logic m;
      case (size)
         2'd0:    m = 1'b0;
         2'd1:    m = off[0];
         2'd2:    m = (off != 2'd0);
         default: m = 1'b1;
      endcase
      return m;
   endfunction

   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] m;
      case (size)
         2'd0:    m = 4'b0001 << off;
         2'd1:    m = 4'b0011 << off;
         default: m = 4'hF;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
      logic [31:0] r;
      case (size)
         2'd0:    r = {4{d[7:0]}};
         2'd1:    r = {2{d[15:0]}};
         default: r = d;
      endcase
      return r;
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? {PW{1'b0}} : p + PW'(1);
   endfunction

   assign full_s         = (cnt_r == CNT_FULL);
   assign empty_s        = (cnt_r == {CW{1'b0}});
   assign core_req_rdy_o = !full_s && (!p0_uvld_o || p0_urdy_i);
   assign push_s         = core_req_vld_i && core_req_rdy_o;
   assign mis_s          = misaligned(core_req_size_i, core_req_addr_i[1:0]);
   assign new_tag_s      = '{err: mis_s, we: core_req_we_i, size: core_req_size_i,
                             sgn: core_req_signed_i, off: core_req_addr_i[1:0]};

   // An err head answers on its own; a cache-backed head waits for p0 data.
   assign head_s         = fifo_r[rd_ptr_r];
   assign core_rsp_vld_o = !empty_s && (head_s.err || p0_dvld_i);
   assign p0_drdy_o      = !empty_s && !head_s.err && core_rsp_rdy_i;
   assign core_rsp_err_o = core_rsp_vld_o && head_s.err;
   assign pop_s          = core_rsp_vld_o && core_rsp_rdy_i;

   // Tag FIFO storage, pointers and occupancy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            fifo_r[i] <= '0;
         end
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         cnt_r    <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            fifo_r[wr_ptr_r] <= new_tag_s;
            wr_ptr_r         <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   cnt_r <= cnt_r + CW'(1);
            2'b01:   cnt_r <= cnt_r - CW'(1);
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   // p0 request register; accept is only possible when the slot is free or draining
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p0_uvld_o  <= 1'b0;
         p0_addr_o  <= 32'h0;
         p0_web_o   <= 1'b1;
         p0_wdat_o  <= 32'h0;
         p0_wmask_o <= 4'h0;
      end else if (push_s && !mis_s) begin
         p0_uvld_o  <= 1'b1;
         p0_addr_o  <= {core_req_addr_i[31:2], 2'b00};
         p0_web_o   <= !core_req_we_i;
         p0_wdat_o  <= core_req_we_i ? lane_data(core_req_size_i, core_req_wdat_i) : 32'h0;
         p0_wmask_o <= core_req_we_i ? lane_mask(core_req_size_i, core_req_addr_i[1:0]) : 4'h0;
      end else if (p0_uvld_o && p0_urdy_i) begin
         p0_uvld_o <= 1'b0;
      end
   end

   // Load lane extraction and sign/zero extension from the FIFO head
   always_comb begin
      ext_s = 32'h0;
      case (head_s.size)
         2'd0: begin
            ext_s[7:0]  = p0_ddat_i[{head_s.off, 3'b000} +: 8];
            ext_s[31:8] = {24{head_s.sgn && ext_s[7]}};
         end
         2'd1: begin
            ext_s[15:0]  = p0_ddat_i[{head_s.off[1], 4'b0000} +: 16];
            ext_s[31:16] = {16{head_s.sgn && ext_s[15]}};
         end
         2'd2:    ext_s = p0_ddat_i;
         default: ext_s = 32'h0;
      endcase
      if (head_s.err || head_s.we) begin
         core_rsp_dat_o = 32'h0;
      end else begin
         core_rsp_dat_o = ext_s;
      end
   end

`ifdef CACHE_LSU_PORT_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Saturating activity counters; clear takes priority over increment
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_load_cnt_o  <= 16'h0;
         stat_store_cnt_o <= 16'h0;
         stat_stall_cnt_o <= 16'h0;
      end else if (stat_clr_i) begin
         stat_load_cnt_o  <= 16'h0;
         stat_store_cnt_o <= 16'h0;
         stat_stall_cnt_o <= 16'h0;
      end else begin
         if (p0_uvld_o && p0_urdy_i && p0_web_o) begin
            stat_load_cnt_o <= sat_inc(stat_load_cnt_o);
         end
         if (p0_uvld_o && p0_urdy_i && !p0_web_o) begin
            stat_store_cnt_o <= sat_inc(stat_store_cnt_o);
         end
         if (p0_uvld_o && !p0_urdy_i) begin
            stat_stall_cnt_o <= sat_inc(stat_stall_cnt_o);
         end
      end
   end
`endif

   cache_lsu_port_chk u_chk (
      .clk        (clk),
      .reset      (reset),
      .p0_dvld_i  (p0_dvld_i),
      .fifo_empty (empty_s),
      .head_err   (head_s.err)
   );

endmodule

// Protocol checker: cache data must only arrive for a cache-backed FIFO head.
module cache_lsu_port_chk (
   input logic clk,
   input logic reset,
   input logic p0_dvld_i,
   input logic fifo_empty,
   input logic head_err
);

   a_dvld_expected: assert property (@(posedge clk) disable iff (!reset)
      !(p0_dvld_i && (fifo_empty || head_err)))
      else $error("p0_dvld_i asserted with no cache-backed request at FIFO head");

endmodule

// File: tb/tb_cache_lsu_port.sv
// Directed self-checking bench for cache_lsu_port (MAX_OUTSTANDING = 2).
module tb_cache_lsu_port;

   logic        clk = 1'b0;
   logic        reset;
   logic        core_req_vld_i;
   logic        core_req_rdy_o;
   logic [31:0] core_req_addr_i;
   logic        core_req_we_i;
   logic [1:0]  core_req_size_i;
   logic        core_req_signed_i;
   logic [31:0] core_req_wdat_i;
   logic        core_rsp_vld_o;
   logic        core_rsp_rdy_i;
   logic [31:0] core_rsp_dat_o;
   logic        core_rsp_err_o;
   logic        p0_uvld_o;
   logic        p0_urdy_i;
   logic [31:0] p0_addr_o;
   logic        p0_web_o;
   logic [31:0] p0_wdat_o;
   logic [3:0]  p0_wmask_o;
   logic        p0_dvld_i;
   logic        p0_drdy_o;
   logic [31:0] p0_ddat_i;
`ifdef CACHE_LSU_PORT_STATS_EN
   logic        stat_clr_i;
   logic [15:0] stat_load_cnt_o;
   logic [15:0] stat_store_cnt_o;
   logic [15:0] stat_stall_cnt_o;
`endif

   int checks   = 0;
   int failures = 0;

   cache_lsu_port #(.MAX_OUTSTANDING(2)) dut (
      .clk               (clk),
      .reset             (reset),
      .core_req_vld_i    (core_req_vld_i),
      .core_req_rdy_o    (core_req_rdy_o),
      .core_req_addr_i   (core_req_addr_i),
      .core_req_we_i     (core_req_we_i),
      .core_req_size_i   (core_req_size_i),
      .core_req_signed_i (core_req_signed_i),
      .core_req_wdat_i   (core_req_wdat_i),
      .core_rsp_vld_o    (core_rsp_vld_o),
      .core_rsp_rdy_i    (core_rsp_rdy_i),
      .core_rsp_dat_o    (core_rsp_dat_o),
      .core_rsp_err_o    (core_rsp_err_o),
      .p0_uvld_o         (p0_uvld_o),
      .p0_urdy_i         (p0_urdy_i),
      .p0_addr_o         (p0_addr_o),
      .p0_web_o          (p0_web_o),
      .p0_wdat_o         (p0_wdat_o),
      .p0_wmask_o        (p0_wmask_o),
      .p0_dvld_i         (p0_dvld_i),
      .p0_drdy_o         (p0_drdy_o),
      .p0_ddat_i         (p0_ddat_i)
`ifdef CACHE_LSU_PORT_STATS_EN
      ,
      .stat_clr_i        (stat_clr_i),
      .stat_load_cnt_o   (stat_load_cnt_o),
      .stat_store_cnt_o  (stat_store_cnt_o),
      .stat_stall_cnt_o  (stat_stall_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Drive point just after the active edge; check point on the falling edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic sgn, input logic [31:0] data, input logic [31:0] exp_addr,
                          input logic [31:0] exp_dat);
      step();
      core_req_vld_i = 1'b1; core_req_addr_i = addr; core_req_we_i = 1'b0;
      core_req_size_i = size; core_req_signed_i = sgn; core_req_wdat_i = 32'h0;
      step();
      core_req_vld_i = 1'b0;
      settle();
      check_eq({tag, "_uvld"}, p0_uvld_o, 32'd1);
      check_eq({tag, "_addr"}, p0_addr_o, exp_addr);
      check_eq({tag, "_web"}, p0_web_o, 32'd1);
      check_eq({tag, "_wmask"}, p0_wmask_o, 32'd0);
      step();
      p0_dvld_i = 1'b1; p0_ddat_i = data; core_rsp_rdy_i = 1'b1;
      settle();
      check_eq({tag, "_rsp_vld"}, core_rsp_vld_o, 32'd1);
      check_eq({tag, "_rsp_err"}, core_rsp_err_o, 32'd0);
      check_eq({tag, "_rsp_dat"}, core_rsp_dat_o, exp_dat);
      check_eq({tag, "_drdy"}, p0_drdy_o, 32'd1);
      step();
      p0_dvld_i = 1'b0; core_rsp_rdy_i = 1'b0;
      settle();
      check_eq({tag, "_rsp_idle"}, core_rsp_vld_o, 32'd0);
   endtask

   task automatic do_err(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic we);
      step();
      core_req_vld_i = 1'b1; core_req_addr_i = addr; core_req_we_i = we;
      core_req_size_i = size; core_req_signed_i = 1'b0; core_req_wdat_i = 32'h5A5A5A5A;
      settle();
      check_eq({tag, "_rdy"}, core_req_rdy_o, 32'd1);
      step();
      core_req_vld_i = 1'b0;
      settle();
      check_eq({tag, "_no_uvld"}, p0_uvld_o, 32'd0);
      check_eq({tag, "_rsp_vld"}, core_rsp_vld_o, 32'd1);
      check_eq({tag, "_rsp_err"}, core_rsp_err_o, 32'd1);
      check_eq({tag, "_rsp_dat"}, core_rsp_dat_o, 32'd0);
      check_eq({tag, "_drdy"}, p0_drdy_o, 32'd0);
      core_rsp_rdy_i = 1'b1;
      step();
      core_rsp_rdy_i = 1'b0;
      settle();
      check_eq({tag, "_rsp_idle"}, core_rsp_vld_o, 32'd0);
   endtask

   initial begin
      reset = 1'b0;
      core_req_vld_i = 1'b0; core_req_addr_i = 32'h0; core_req_we_i = 1'b0;
      core_req_size_i = 2'd0; core_req_signed_i = 1'b0; core_req_wdat_i = 32'h0;
      core_rsp_rdy_i = 1'b0; p0_urdy_i = 1'b1; p0_dvld_i = 1'b0; p0_ddat_i = 32'h0;
`ifdef CACHE_LSU_PORT_STATS_EN
      stat_clr_i = 1'b0;
`endif
      step(); step();
      settle();
      check_eq("rst_uvld", p0_uvld_o, 32'd0);
      check_eq("rst_addr", p0_addr_o, 32'd0);
      check_eq("rst_web", p0_web_o, 32'd1);
      check_eq("rst_wdat", p0_wdat_o, 32'd0);
      check_eq("rst_wmask", p0_wmask_o, 32'd0);
      check_eq("rst_rsp_vld", core_rsp_vld_o, 32'd0);
      check_eq("rst_rsp_err", core_rsp_err_o, 32'd0);
      check_eq("rst_req_rdy", core_req_rdy_o, 32'd1);
      reset = 1'b1;

      // Byte store at lane 3
      step();
      core_req_vld_i = 1'b1; core_req_addr_i = 32'h1003; core_req_we_i = 1'b1;
      core_req_size_i = 2'd0; core_req_wdat_i = 32'h000000A5;
      settle();
      check_eq("stb_rdy", core_req_rdy_o, 32'd1);
      step();
      core_req_vld_i = 1'b0;
      settle();
      check_eq("stb_uvld", p0_uvld_o, 32'd1);
      check_eq("stb_addr", p0_addr_o, 32'h00001000);
      check_eq("stb_web", p0_web_o, 32'd0);
      check_eq("stb_wmask", p0_wmask_o, 32'h8);
      check_eq("stb_wdat", p0_wdat_o, 32'hA5A5A5A5);
      step();
      p0_dvld_i = 1'b1; p0_ddat_i = 32'hDEADBEEF; core_rsp_rdy_i = 1'b1;
      settle();
      check_eq("stb_uvld_drop", p0_uvld_o, 32'd0);
      check_eq("stb_rsp_vld", core_rsp_vld_o, 32'd1);
      check_eq("stb_rsp_err", core_rsp_err_o, 32'd0);
      check_eq("stb_rsp_dat", core_rsp_dat_o, 32'd0);
      step();
      p0_dvld_i = 1'b0; core_rsp_rdy_i = 1'b0;
      settle();
      check_eq("stb_rsp_idle", core_rsp_vld_o, 32'd0);

      do_load("ldh_s", 32'h2002, 2'd1, 1'b1, 32'h80011234, 32'h2000, 32'hFFFF8001);
      do_load("ldh_u", 32'h2002, 2'd1, 1'b0, 32'h80011234, 32'h2000, 32'h00008001);
      do_load("ldb_s", 32'h4001, 2'd0, 1'b1, 32'h123480FF, 32'h4000, 32'hFFFFFF80);
      do_load("ldb_u", 32'h4002, 2'd0, 1'b0, 32'h12F480FF, 32'h4000, 32'h000000F4);
      do_load("ldw", 32'h4004, 2'd2, 1'b1, 32'h87654321, 32'h4004, 32'h87654321);

      do_err("err_w", 32'h3001, 2'd2, 1'b0);
      do_err("err_h", 32'h3003, 2'd1, 1'b1);
      do_err("err_rsv", 32'h3000, 2'd3, 1'b0);

      // In-order pipeline: A (load), B (misaligned), C (load)
      step();
      core_req_vld_i = 1'b1; core_req_addr_i = 32'h5000; core_req_we_i = 1'b0;
      core_req_size_i = 2'd2; core_req_signed_i = 1'b0;
      step();
      core_req_addr_i = 32'h5002;
      settle();
      check_eq("pipe_rdy_b", core_req_rdy_o, 32'd1);
      step();
      core_req_addr_i = 32'h5004;
      settle();
      check_eq("pipe_full_rdy", core_req_rdy_o, 32'd0);
      check_eq("pipe_b_held", core_rsp_vld_o, 32'd0);
      step();
      p0_dvld_i = 1'b1; p0_ddat_i = 32'h11223344; core_rsp_rdy_i = 1'b1;
      settle();
      check_eq("pipe_rdy_pop_cycle", core_req_rdy_o, 32'd0);
      check_eq("pipe_a_vld", core_rsp_vld_o, 32'd1);
      check_eq("pipe_a_err", core_rsp_err_o, 32'd0);
      check_eq("pipe_a_dat", core_rsp_dat_o, 32'h11223344);
      step();
      p0_dvld_i = 1'b0;
      settle();
      check_eq("pipe_b_vld", core_rsp_vld_o, 32'd1);
      check_eq("pipe_b_err", core_rsp_err_o, 32'd1);
      check_eq("pipe_b_dat", core_rsp_dat_o, 32'd0);
      check_eq("pipe_rdy_c", core_req_rdy_o, 32'd1);
      step();
      core_req_vld_i = 1'b0;
      settle();
      check_eq("pipe_c_wait", core_rsp_vld_o, 32'd0);
      check_eq("pipe_c_uvld", p0_uvld_o, 32'd1);
      check_eq("pipe_c_addr", p0_addr_o, 32'h00005004);
      step();
      p0_dvld_i = 1'b1; p0_ddat_i = 32'hCAFEF00D;
      settle();
      check_eq("pipe_c_vld", core_rsp_vld_o, 32'd1);
      check_eq("pipe_c_err", core_rsp_err_o, 32'd0);
      check_eq("pipe_c_dat", core_rsp_dat_o, 32'hCAFEF00D);
      step();
      p0_dvld_i = 1'b0; core_rsp_rdy_i = 1'b0;
      settle();
      check_eq("pipe_idle", core_rsp_vld_o, 32'd0);

      // Backpressure: half store held for 5 stalled cycles
      step();
      p0_urdy_i = 1'b0;
      core_req_vld_i = 1'b1; core_req_addr_i = 32'h6002; core_req_we_i = 1'b1;
      core_req_size_i = 2'd1; core_req_wdat_i = 32'h0000BEEF;
      settle();
      check_eq("bp_rdy", core_req_rdy_o, 32'd1);
      step();
      core_req_vld_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         settle();
         check_eq("bp_uvld", p0_uvld_o, 32'd1);
         check_eq("bp_addr", p0_addr_o, 32'h00006000);
         check_eq("bp_web", p0_web_o, 32'd0);
         check_eq("bp_wmask", p0_wmask_o, 32'hC);
         check_eq("bp_wdat", p0_wdat_o, 32'hBEEFBEEF);
         check_eq("bp_req_rdy", core_req_rdy_o, 32'd0);
         step();
      end
      p0_urdy_i = 1'b1;
      settle();
      check_eq("bp_uvld_final", p0_uvld_o, 32'd1);
`ifdef CACHE_LSU_PORT_STATS_EN
      check_eq("bp_stall_cnt", stat_stall_cnt_o, 32'd5);
`endif
      step();
      p0_dvld_i = 1'b1; p0_ddat_i = 32'h0; core_rsp_rdy_i = 1'b1;
      settle();
      check_eq("bp_one_hs", p0_uvld_o, 32'd0);
      check_eq("bp_rsp_vld", core_rsp_vld_o, 32'd1);
      check_eq("bp_rsp_dat", core_rsp_dat_o, 32'd0);
      step();
      p0_dvld_i = 1'b0; core_rsp_rdy_i = 1'b0;
`ifdef CACHE_LSU_PORT_STATS_EN
      settle();
      check_eq("st_load_cnt", stat_load_cnt_o, 32'd7);
      check_eq("st_store_cnt", stat_store_cnt_o, 32'd2);
      stat_clr_i = 1'b1;
      step();
      stat_clr_i = 1'b0;
      settle();
      check_eq("st_clr_load", stat_load_cnt_o, 32'd0);
      check_eq("st_clr_stall", stat_stall_cnt_o, 32'd0);
`endif

      // Reset with two requests in flight
      step();
      core_req_vld_i = 1'b1; core_req_addr_i = 32'h7000; core_req_we_i = 1'b0;
      core_req_size_i = 2'd2;
      step();
      core_req_addr_i = 32'h7004;
      step();
      core_req_vld_i = 1'b0;
      settle();
      check_eq("rm_full", core_req_rdy_o, 32'd0);
      check_eq("rm_uvld_pre", p0_uvld_o, 32'd1);
      reset = 1'b0;
      step();
      check_eq("rm_uvld", p0_uvld_o, 32'd0);
      check_eq("rm_rsp_vld", core_rsp_vld_o, 32'd0);
      check_eq("rm_req_rdy", core_req_rdy_o, 32'd1);
      settle();
      reset = 1'b1;
      step();
      settle();
      check_eq("rm_post_rsp_vld", core_rsp_vld_o, 32'd0);
      check_eq("rm_post_rdy", core_req_rdy_o, 32'd1);
      do_load("post_rst", 32'h8000, 2'd2, 1'b0, 32'h0BADF00D, 32'h8000, 32'h0BADF00D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
